// File: rtl/obj_list_renderer.sv
// ---------------------------------------------------------------------------
// obj_list_renderer
//
// Multi-object rasteriser for the 640x480 VGA path. It sits between the
// object producer and vga_driver's pix_data input.
//
// The host fills a shadow object list and a shadow length, then requests a
// commit. The shadow list is copied to the active list at the next
// frame_start, which falls in vertical blanking, so a frame is never drawn
// from a half-updated list.
//
// Every pixel is tested against every active object in a fixed 3-stage
// pipeline with no stalls:
//   S1  register coordinates and the on-screen flag
//   S2  per-slot hit test against the active list
//   S3  highest-index hit wins; its colour is registered onto pix_data
//
// Object word (56 bits):
//   [55:52] shape  0 off, 1 rect, 2 filled circle, 3 ring, 4-15 off
//   [51:42] x      rect corner or circle centre
//   [41:32] y
//   [31:22] w      rect width or outer radius
//   [21:12] h      rect height or inner radius
//   [11:0]  colour RGB444
//
// Ports:
//   clk25          pixel clock
//   rst            asynchronous active-low reset
//   pix_x, pix_y   current column/row from vga_driver
//   frame_start    one-cycle pulse at start of vertical blanking
//   wr_en, wr_addr, wr_data   shadow slot write
//   len_wr, len_data          shadow length load (clamped to MAX_LEN)
//   commit         one-cycle request to publish the shadow list
//   commit_pending commit requested but not yet applied
//   pix_data       RGB444 pixel, 3 cycles after pix_x/pix_y
//
// Optional feature, macro OBJ_HIT_INDEX_EN:
//   adds hit_valid / hit_idx, aligned with pix_data, reporting whether an
//   on-screen object was selected and which slot won.
// ---------------------------------------------------------------------------
module obj_list_renderer #(
  parameter int          OBJ_WIDTH = 56,
  parameter int          MAX_LEN   = 16,
  parameter int          AW        = $clog2(MAX_LEN),
  parameter logic [11:0] BG_COLOR  = 12'h000,
  parameter int          H_ACTIVE  = 640,
  parameter int          V_ACTIVE  = 480
) (
  input  logic                 clk25,
  input  logic                 rst,
  input  logic [9:0]           pix_x,
  input  logic [9:0]           pix_y,
  input  logic                 frame_start,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [OBJ_WIDTH-1:0] wr_data,
  input  logic                 len_wr,
  input  logic [5:0]           len_data,
  input  logic                 commit,
  output logic                 commit_pending,
  output logic [11:0]          pix_data
`ifdef OBJ_HIT_INDEX_EN
  ,
  output logic                 hit_valid,
  output logic [AW-1:0]        hit_idx
`endif
);

  localparam int LW = 6;

  typedef struct packed {
    logic [3:0]  shape;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [9:0]  w;
    logic [9:0]  h;
    logic [11:0] colour;
  } obj_t;

  localparam logic [3:0] SHAPE_RECT   = 4'd1;
  localparam logic [3:0] SHAPE_CIRCLE = 4'd2;
  localparam logic [3:0] SHAPE_RING   = 4'd3;

  // -------------------------------------------------------------------------
  // Geometry test for one object against one pixel.
  // Rect bounds are 11-bit so x+w never wraps; circle/ring compare squared
  // distances, so no square root is needed.
  // -------------------------------------------------------------------------
  function automatic logic obj_hit(
    input logic [3:0] shape,
    input logic [9:0] ox,
    input logic [9:0] oy,
    input logic [9:0] ow,
    input logic [9:0] oh,
    input logic [9:0] px,
    input logic [9:0] py
  );
    logic [10:0] x_end;
    logic [10:0] y_end;
    logic [9:0]  dx;
    logic [9:0]  dy;
    logic [19:0] dx2;
    logic [19:0] dy2;
    logic [20:0] d2;
    logic [19:0] ro2;
    logic [19:0] ri2;
    logic        hit;

    x_end = {1'b0, ox} + {1'b0, ow};
    y_end = {1'b0, oy} + {1'b0, oh};
    dx    = (px >= ox) ? (px - ox) : (ox - px);
    dy    = (py >= oy) ? (py - oy) : (oy - py);
    dx2   = {10'd0, dx} * {10'd0, dx};
    dy2   = {10'd0, dy} * {10'd0, dy};
    d2    = {1'b0, dx2} + {1'b0, dy2};
    ro2   = {10'd0, ow} * {10'd0, ow};
    ri2   = {10'd0, oh} * {10'd0, oh};

    case (shape)
      SHAPE_RECT:
        hit = (px >= ox) && ({1'b0, px} < x_end) &&
              (py >= oy) && ({1'b0, py} < y_end);
      SHAPE_CIRCLE:
        hit = (d2 <= {1'b0, ro2});
      // An inner radius larger than the outer one leaves an empty band.
      SHAPE_RING:
        hit = ({1'b0, ri2} <= d2) && (d2 <= {1'b0, ro2});
      default:
        hit = 1'b0;
    endcase
    return hit;
  endfunction

  // -------------------------------------------------------------------------
  // Shadow / active object lists
  // -------------------------------------------------------------------------
  obj_t            shadow_q [MAX_LEN];
  obj_t            active_q [MAX_LEN];
  logic [LW-1:0]   shadow_len_q;
  logic [LW-1:0]   active_len_q;
  logic            commit_pending_q;
  logic            commit_pending_d;
  logic            do_copy;
  logic [LW-1:0]   len_clamped;
  logic [MAX_LEN-1:0] slot_wr;

  // Decoding the address per slot means an out-of-range address simply
  // selects nothing, without a separate range check.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned, which would infer a latch.
    slot_wr = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (wr_en && (wr_addr == AW'(i))) begin
        slot_wr[i] = 1'b1;
      end
    end
  end

  assign len_clamped = (len_data > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len_data;

  // A commit in the frame_start cycle is applied at once and never pends;
  // repeated commits before frame_start collapse into a single copy.
  assign do_copy          = frame_start && (commit_pending_q || commit);
  assign commit_pending_d = frame_start ? 1'b0 : (commit_pending_q || commit);

  always_ff @(posedge clk25 or negedge rst) begin
    if (!rst) begin
      // NOTE: the object lists are cleared on reset so every slot powers up
      // disabled; this keeps them in flops rather than a RAM macro, which
      // is acceptable at this list size.
      for (int i = 0; i < MAX_LEN; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      shadow_len_q     <= '0;
      active_len_q     <= '0;
      commit_pending_q <= 1'b0;
    end else begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (slot_wr[i]) begin
          shadow_q[i] <= wr_data;
        end
      end
      if (len_wr) begin
        shadow_len_q <= len_clamped;
      end
      // NOTE: non-blocking assignment makes the copy read the shadow list
      // as it was before this edge, so a write in the copy cycle lands in
      // the shadow list only.
      if (do_copy) begin
        active_q     <= shadow_q;
        active_len_q <= shadow_len_q;
      end
      commit_pending_q <= commit_pending_d;
    end
  end

  assign commit_pending = commit_pending_q;

  // -------------------------------------------------------------------------
  // S1: coordinates and on-screen flag
  // -------------------------------------------------------------------------
  logic [9:0] px_q;
  logic [9:0] py_q;
  logic       in_screen1_q;
  logic       in_screen1_d;

  assign in_screen1_d = (pix_x < 10'(H_ACTIVE)) && (pix_y < 10'(V_ACTIVE));

  // -------------------------------------------------------------------------
  // S2: per-slot hit test. Colours are captured alongside the hits so S3
  // sees the same list snapshot the hit test used.
  // -------------------------------------------------------------------------
  logic [MAX_LEN-1:0] hit_d;
  logic [MAX_LEN-1:0] hit_q;
  logic [11:0]        colour_q [MAX_LEN];
  logic               in_screen2_q;

  always_comb begin
    hit_d = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      hit_d[i] = (LW'(i) < active_len_q) &&
                 obj_hit(active_q[i].shape, active_q[i].x, active_q[i].y,
                         active_q[i].w, active_q[i].h, px_q, py_q);
    end
  end

  // -------------------------------------------------------------------------
  // S3: highest-index hit wins (later loop iterations override earlier ones)
  // -------------------------------------------------------------------------
  logic          sel_found;
  logic [AW-1:0] sel_idx;
  logic [11:0]   pix_data_d;
  logic [11:0]   pix_data_q;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (hit_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = AW'(i);
      end
    end
    if (!in_screen2_q) begin
      pix_data_d = 12'h000;
    end else if (sel_found) begin
      pix_data_d = colour_q[sel_idx];
    end else begin
      pix_data_d = BG_COLOR;
    end
  end

`ifdef OBJ_HIT_INDEX_EN
  logic          hit_valid_q;
  logic [AW-1:0] hit_idx_q;
  logic          hit_valid_d;
  logic [AW-1:0] hit_idx_d;

  assign hit_valid_d = in_screen2_q && sel_found;
  assign hit_idx_d   = hit_valid_d ? sel_idx : '0;
`endif

  always_ff @(posedge clk25 or negedge rst) begin
    if (!rst) begin
      px_q         <= '0;
      py_q         <= '0;
      in_screen1_q <= 1'b0;
      hit_q        <= '0;
      for (int i = 0; i < MAX_LEN; i++) begin
        colour_q[i] <= '0;
      end
      in_screen2_q <= 1'b0;
      pix_data_q   <= '0;
`ifdef OBJ_HIT_INDEX_EN
      hit_valid_q  <= 1'b0;
      hit_idx_q    <= '0;
`endif
    end else begin
      px_q         <= pix_x;
      py_q         <= pix_y;
      in_screen1_q <= in_screen1_d;
      hit_q        <= hit_d;
      for (int i = 0; i < MAX_LEN; i++) begin
        colour_q[i] <= active_q[i].colour;
      end
      in_screen2_q <= in_screen1_q;
      pix_data_q   <= pix_data_d;
`ifdef OBJ_HIT_INDEX_EN
      hit_valid_q  <= hit_valid_d;
      hit_idx_q    <= hit_idx_d;
`endif
    end
  end

  assign pix_data = pix_data_q;

`ifdef OBJ_HIT_INDEX_EN
  assign hit_valid = hit_valid_q;
  assign hit_idx   = hit_idx_q;
`endif

endmodule

// File: tb/tb_obj_list_renderer.sv
// ---------------------------------------------------------------------------
// tb_obj_list_renderer
//
// Directed bench for obj_list_renderer. Pixel probes come from small tables
// of {coordinate, expected colour, expected winning slot}; commit timing,
// latency and reset are exercised by hand-written sequences. A non-black
// background colour is used so "no hit" and "off screen" are distinguishable.
// ---------------------------------------------------------------------------
module tb_obj_list_renderer;

  localparam int          MAX_LEN = 16;
  localparam int          AW      = 4;
  localparam logic [11:0] BG      = 12'h5A5;

  logic          clk25 = 1'b0;
  logic          rst;
  logic [9:0]    pix_x;
  logic [9:0]    pix_y;
  logic          frame_start;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [55:0]   wr_data;
  logic          len_wr;
  logic [5:0]    len_data;
  logic          commit;
  logic          commit_pending;
  logic [11:0]   pix_data;
`ifdef OBJ_HIT_INDEX_EN
  logic          hit_valid;
  logic [AW-1:0] hit_idx;
`endif

  always #20 clk25 = ~clk25;

  obj_list_renderer #(
    .OBJ_WIDTH (56),
    .MAX_LEN   (MAX_LEN),
    .AW        (AW),
    .BG_COLOR  (BG),
    .H_ACTIVE  (640),
    .V_ACTIVE  (480)
  ) dut (
    .clk25          (clk25),
    .rst            (rst),
    .pix_x          (pix_x),
    .pix_y          (pix_y),
    .frame_start    (frame_start),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .len_wr         (len_wr),
    .len_data       (len_data),
    .commit         (commit),
    .commit_pending (commit_pending),
    .pix_data       (pix_data)
`ifdef OBJ_HIT_INDEX_EN
    ,
    .hit_valid      (hit_valid),
    .hit_idx        (hit_idx)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [9:0]    x;
    logic [9:0]    y;
    logic [11:0]   pix;
    logic          hv;
    logic [AW-1:0] idx;
  } vec_t;

  vec_t vq[$];

  function automatic logic [55:0] mk(input logic [3:0] s, input logic [9:0] x,
                                     input logic [9:0] y, input logic [9:0] w,
                                     input logic [9:0] h, input logic [11:0] c);
    return {s, x, y, w, h, c};
  endfunction

  task automatic step();
    @(posedge clk25);
    #1;
  endtask

  task automatic add(input logic [9:0] x, input logic [9:0] y, input logic [11:0] pix,
                     input logic hv, input logic [AW-1:0] idx);
    vq.push_back('{x: x, y: y, pix: pix, hv: hv, idx: idx});
  endtask

  task automatic write_obj(input int a, input logic [55:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic set_len(input logic [5:0] n);
    len_wr   = 1'b1;
    len_data = n;
    step();
    len_wr   = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic publish();
    pulse_commit();
    pulse_fs();
  endtask

  task automatic probe(input string tag, input vec_t v);
    string nm;
    pix_x = v.x;
    pix_y = v.y;
    repeat (3) step();
    nm = $sformatf("%s(%0d,%0d)", tag, v.x, v.y);
    check({nm, ".pix"}, 32'(pix_data), 32'(v.pix));
`ifdef OBJ_HIT_INDEX_EN
    check({nm, ".hit_valid"}, 32'(hit_valid), 32'(v.hv));
    check({nm, ".hit_idx"}, 32'(hit_idx), 32'(v.idx));
`endif
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      probe(tag, vq[i]);
    end
    vq.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; pix_x = '0; pix_y = '0; frame_start = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    len_wr = 1'b0; len_data = '0; commit = 1'b0;
    repeat (3) step();
    check("reset.pix", 32'(pix_data), 32'h0);
    check("reset.pending", 32'(commit_pending), 32'h0);
    rst = 1'b1;
    step();

    // Empty list published: on-screen is background, off-screen black.
    pulse_commit();
    check("empty.pending_set", 32'(commit_pending), 32'h1);
    pulse_fs();
    check("empty.pending_clr", 32'(commit_pending), 32'h0);
    add(0, 0, BG, 0, 0);
    add(639, 479, BG, 0, 0);
    add(320, 240, BG, 0, 0);
    add(640, 0, 12'h000, 0, 0);
    add(0, 480, 12'h000, 0, 0);
    run_table("empty");

    // Rectangle edges, plus an object straddling the screen edge.
    write_obj(0, mk(1, 100, 100, 50, 40, 12'hF00));
    write_obj(1, mk(1, 600, 470, 100, 100, 12'h0F0));
    set_len(2);
    publish();
    add(100, 100, 12'hF00, 1, 0);
    add(149, 139, 12'hF00, 1, 0);
    add(150, 100, BG, 0, 0);
    add(100, 140, BG, 0, 0);
    add(99, 100, BG, 0, 0);
    add(639, 479, 12'h0F0, 1, 1);
    add(640, 475, 12'h000, 0, 0);
    add(600, 480, 12'h000, 0, 0);
    run_table("rect");

    // Latency: a one-cycle coordinate blip appears exactly 3 cycles later.
    pix_x = 0; pix_y = 0;
    repeat (4) step();
    pix_x = 100; pix_y = 100;
    step();
    pix_x = 0; pix_y = 0;
    step();
    check("latency.c2", 32'(pix_data), 32'(BG));
    step();
    check("latency.c3", 32'(pix_data), 32'hF00);
    step();
    check("latency.c4", 32'(pix_data), 32'(BG));

    // Priority: circle in slot 3 over rect in slot 0; zero-radius circle.
    write_obj(0, mk(1, 100, 100, 100, 100, 12'hF00));
    write_obj(1, 56'h0);
    write_obj(3, mk(2, 150, 150, 20, 0, 12'h0F0));
    write_obj(4, mk(2, 300, 300, 0, 0, 12'hABC));
    set_len(5);
    publish();
    add(150, 150, 12'h0F0, 1, 3);
    add(150, 171, 12'hF00, 1, 0);
    add(101, 101, 12'hF00, 1, 0);
    add(170, 150, 12'h0F0, 1, 3);
    add(171, 150, 12'hF00, 1, 0);
    add(150, 130, 12'h0F0, 1, 3);
    add(200, 100, BG, 0, 0);
    add(99, 99, BG, 0, 0);
    add(300, 300, 12'hABC, 1, 4);
    add(301, 300, BG, 0, 0);
    run_table("prio");

    // Ring; slot 1 uses an undefined shape code covering the whole screen.
    write_obj(0, mk(3, 320, 240, 30, 20, 12'h00F));
    write_obj(1, mk(5, 0, 0, 640, 480, 12'hFFF));
    set_len(2);
    publish();
    add(350, 240, 12'h00F, 1, 0);
    add(340, 240, 12'h00F, 1, 0);
    add(339, 240, BG, 0, 0);
    add(320, 240, BG, 0, 0);
    add(290, 240, 12'h00F, 1, 0);
    add(351, 240, BG, 0, 0);
    add(320, 270, 12'h00F, 1, 0);
    run_table("ring");

    // Inner radius larger than outer: never hits.
    write_obj(0, mk(3, 320, 240, 30, 40, 12'h00F));
    publish();
    add(350, 240, BG, 0, 0);
    add(340, 240, BG, 0, 0);
    add(320, 240, BG, 0, 0);
    add(300, 240, BG, 0, 0);
    run_table("ring_inv");

    // Commit mid-frame takes effect only at frame_start.
    write_obj(0, mk(1, 0, 0, 640, 480, 12'hF00));
    set_len(1);
    publish();
    probe("mid.before", '{x: 10, y: 10, pix: 12'hF00, hv: 1, idx: 0});
    write_obj(0, mk(1, 0, 0, 640, 480, 12'h0F0));
    pulse_commit();
    check("mid.pending", 32'(commit_pending), 32'h1);
    probe("mid.old", '{x: 10, y: 10, pix: 12'hF00, hv: 1, idx: 0});
    check("mid.pending_hold", 32'(commit_pending), 32'h1);
    pulse_fs();
    check("mid.pending_clr", 32'(commit_pending), 32'h0);
    probe("mid.new", '{x: 10, y: 10, pix: 12'h0F0, hv: 1, idx: 0});

    // Repeated commits coalesce; frame_start without commit changes nothing.
    write_obj(0, mk(1, 0, 0, 640, 480, 12'h00F));
    pulse_commit();
    pulse_commit();
    check("coal.pending", 32'(commit_pending), 32'h1);
    pulse_fs();
    check("coal.pending_clr", 32'(commit_pending), 32'h0);
    probe("coal", '{x: 10, y: 10, pix: 12'h00F, hv: 1, idx: 0});
    write_obj(0, mk(1, 0, 0, 640, 480, 12'hFFF));
    pulse_fs();
    probe("nocommit", '{x: 10, y: 10, pix: 12'h00F, hv: 1, idx: 0});

    // Commit with frame_start, plus a write in the same cycle.
    commit = 1'b1; frame_start = 1'b1;
    wr_en = 1'b1; wr_addr = 0; wr_data = mk(1, 0, 0, 640, 480, 12'h777);
    step();
    commit = 1'b0; frame_start = 1'b0; wr_en = 1'b0;
    check("coinc.pending", 32'(commit_pending), 32'h0);
    probe("coinc", '{x: 10, y: 10, pix: 12'hFFF, hv: 1, idx: 0});
    commit = 1'b1; frame_start = 1'b1;
    step();
    commit = 1'b0; frame_start = 1'b0;
    probe("coinc.wr", '{x: 10, y: 10, pix: 12'h777, hv: 1, idx: 0});

    // Length clamp: 40 becomes 16, so slot 15 is live; 15 leaves it out.
    write_obj(15, mk(1, 50, 50, 10, 10, 12'hABC));
    set_len(40);
    publish();
    add(55, 55, 12'hABC, 1, 15);
    add(10, 10, 12'h777, 1, 0);
    run_table("clamp");
    set_len(15);
    publish();
    probe("len15", '{x: 55, y: 55, pix: 12'h777, hv: 1, idx: 0});

    // Reset mid-frame clears outputs at once and drops a pending commit.
    set_len(16);
    publish();
    probe("prerst", '{x: 55, y: 55, pix: 12'hABC, hv: 1, idx: 15});
    pulse_commit();
    check("prerst.pending", 32'(commit_pending), 32'h1);
    rst = 1'b0;
    #2;
    check("rst.pix", 32'(pix_data), 32'h0);
    check("rst.pending", 32'(commit_pending), 32'h0);
`ifdef OBJ_HIT_INDEX_EN
    check("rst.hit_valid", 32'(hit_valid), 32'h0);
`endif
    step();
    rst = 1'b1;
    step();
    pulse_fs();
    check("postrst.pending", 32'(commit_pending), 32'h0);
    probe("postrst", '{x: 55, y: 55, pix: BG, hv: 0, idx: 0});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
